score_display: RTL and testbench

Four-digit BCD score counter and score-overlay renderer. It accepts add requests from game logic and ripples BCD carries one digit per cycle. Each pixel it converts the beam position from the sync generator into a `{digit, yofs}` address for the 5x5 digit bitmap ROM. The returned 5-bit row comes back as a pipelined 1-bit score pixel for the colour mixer.

---
 rtl/score_display_if.sv | 38 +++
 rtl/score_display.sv | 242 ++++++++++++++++++++++++
 tb/tb_score_display.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_display_if.sv
// score_display_if
// Bundles the score adder handshake and the renderer/ROM signals of the
// score overlay block. The clock and the reset stay plain module ports.
//   master : game logic / sync generator / digit ROM side (the bench)
//   slave  : the score_display block itself
// Signals:
//   add_req, add_val, score_clr         -> score update requests
//   busy, add_ack, ovf, score           <- adder status and current BCD score
//   hpos, vpos, display_on              -> beam position from the sync generator
//   digit, yofs                         <- digit ROM address
//   bits                                -> digit ROM row data (bit4 = leftmost)
//   gfx                                 <- score pixel for the colour mixer
interface score_display_if;
  logic        add_req;
  logic [3:0]  add_val;
  logic        score_clr;
  logic        busy;
  logic        add_ack;
  logic        ovf;
  logic [15:0] score;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        display_on;
  logic [3:0]  digit;
  logic [2:0]  yofs;
  logic [4:0]  bits;
  logic        gfx;

  modport master (
    output add_req, add_val, score_clr, hpos, vpos, display_on, bits,
    input  busy, add_ack, ovf, score, digit, yofs, gfx
  );

  modport slave (
    input  add_req, add_val, score_clr, hpos, vpos, display_on, bits,
    output busy, add_ack, ovf, score, digit, yofs, gfx
  );
endinterface

// File: rtl/score_display.sv
// score_display
// Four-digit BCD score counter with a 5x5 bitmap score overlay renderer.
// The adder ripples the BCD carry one digit per cycle through four fixed
// states, so every add takes the same time. The renderer maps the beam
// position onto a {digit, yofs} ROM address and turns the returned ROM row
// into a one-bit pixel two cycles after the position was presented.
// Ports:
//   clk   : pixel clock
//   reset : asynchronous, active-low; clears all state
//   bus   : score_display_if.slave (adder handshake + renderer/ROM signals)
// Parameters:
//   X0, Y0 : left / top edge of the score field in beam coordinates
module score_display #(
  parameter int X0 = 16,
  parameter int Y0 = 8
) (
  input  logic            clk,
  input  logic            reset,
  score_display_if.slave  bus
);

  localparam logic [8:0] X0_V = 9'(X0);
  localparam logic [8:0] Y0_V = 9'(Y0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD0 = 3'd1,
    ADD1 = 3'd2,
    ADD2 = 3'd3,
    ADD3 = 3'd4
  } state_t;

  // One BCD digit step: returns {carry_out, digit_out} for a + b, a <= 9, b <= 9.
  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [4:0] res;
    s = {1'b0, a} + {1'b0, b};
    if (s > 5'd9) begin
      res = {1'b1, 4'(s - 5'd10)};
    end else begin
      res = {1'b0, s[3:0]};
    end
    return res;
  endfunction

  // Out-of-range add amounts saturate at a single decimal digit.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    logic [3:0] res;
    if (v > 4'd9) begin
      res = 4'd9;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Adder FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  addend_q, addend_d;
  logic        carry_q, carry_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  step_s;

  // Next-state and datapath for the BCD ripple adder; clear overrides everything.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    addend_d = addend_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    ovf_d    = 1'b0;
    step_s   = 5'd0;
    if (bus.score_clr) begin
      // An aborted add produces neither ack nor ovf.
      state_d = IDLE;
      score_d = 16'h0000;
      carry_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.add_req) begin
            addend_d = clamp_bcd(bus.add_val);
            carry_d  = 1'b0;
            state_d  = ADD0;
            busy_d   = 1'b1;
          end else begin
            busy_d = 1'b0;
          end
        end
        ADD0: begin
          // The addend only enters the units digit.
          step_s        = bcd_add(score_q[3:0], addend_q);
          score_d[3:0]  = step_s[3:0];
          carry_d       = step_s[4];
          state_d       = ADD1;
        end
        ADD1: begin
          step_s        = bcd_add(score_q[7:4], {3'b000, carry_q});
          score_d[7:4]  = step_s[3:0];
          carry_d       = step_s[4];
          state_d       = ADD2;
        end
        ADD2: begin
          step_s        = bcd_add(score_q[11:8], {3'b000, carry_q});
          score_d[11:8] = step_s[3:0];
          carry_d       = step_s[4];
          state_d       = ADD3;
        end
        ADD3: begin
          // A carry out of the thousands digit means the score wrapped.
          step_s         = bcd_add(score_q[15:12], {3'b000, carry_q});
          score_d[15:12] = step_s[3:0];
          carry_d        = step_s[4];
          ovf_d          = step_s[4];
          ack_d          = 1'b1;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Adder FSM state, score digits and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      score_q  <= 16'h0000;
      addend_q <= 4'd0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      addend_q <= addend_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.add_ack = ack_q;
  assign bus.ovf     = ovf_q;
  assign bus.score   = score_q;

  // ---------------------------------------------------------------------------
  // Renderer
  // ---------------------------------------------------------------------------
  logic [8:0] rx_s, ry_s;
  logic       in_field_s;
  logic [3:0] slot_digit_s;
  logic [3:0] digit_q, digit_d;
  logic [2:0] yofs_q, yofs_d;
  logic [2:0] xofs_q, xofs_d;
  logic       valid_q, valid_d;
  logic       pix_s;
  logic       gfx_q, gfx_d;

  // Beam position to field-relative coordinates; positions left of / above the
  // field wrap to large values and fall outside the range checks.
  always_comb begin
    rx_s       = bus.hpos - X0_V;
    ry_s       = bus.vpos - Y0_V;
    // Columns 5..7 of each 16-pixel slot form the gap between digits.
    in_field_s = bus.display_on && (rx_s < 9'd64) && (ry_s < 9'd10) && (rx_s[3:1] < 3'd5);
  end

  // Slot 0 is the leftmost (most significant) digit.
  always_comb begin
    case (rx_s[5:4])
      2'd0:    slot_digit_s = score_q[15:12];
      2'd1:    slot_digit_s = score_q[11:8];
      2'd2:    slot_digit_s = score_q[7:4];
      2'd3:    slot_digit_s = score_q[3:0];
      default: slot_digit_s = 4'hF;
    endcase
  end

  // Stage-1 inputs: ROM address plus column, forced to a blank address off-field.
  always_comb begin
    if (in_field_s) begin
      digit_d = slot_digit_s;
      yofs_d  = ry_s[3:1];
      xofs_d  = rx_s[3:1];
      valid_d = 1'b1;
    end else begin
      digit_d = 4'hF;
      yofs_d  = 3'd0;
      xofs_d  = 3'd0;
      valid_d = 1'b0;
    end
  end

  // Pick the ROM column; bit4 of the row is the leftmost cell.
  always_comb begin
    case (xofs_q)
      3'd0:    pix_s = bus.bits[4];
      3'd1:    pix_s = bus.bits[3];
      3'd2:    pix_s = bus.bits[2];
      3'd3:    pix_s = bus.bits[1];
      3'd4:    pix_s = bus.bits[0];
      default: pix_s = 1'b0;
    endcase
    gfx_d = valid_q & pix_s;
  end

  // Two-stage pixel pipeline: ROM address stage, then pixel stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= 4'hF;
      yofs_q  <= 3'd0;
      xofs_q  <= 3'd0;
      valid_q <= 1'b0;
      gfx_q   <= 1'b0;
    end else begin
      digit_q <= digit_d;
      yofs_q  <= yofs_d;
      xofs_q  <= xofs_d;
      valid_q <= valid_d;
      gfx_q   <= gfx_d;
    end
  end

  assign bus.digit = digit_q;
  assign bus.yofs  = yofs_q;
  assign bus.gfx   = gfx_q;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display
// Directed self-checking bench for score_display. A behavioural 5x5 font
// ROM answers the DUT's {digit, yofs} address combinationally.
module tb_score_display;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  score_display_if intf ();

  score_display #(.X0(16), .Y0(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 5x5 glyphs, row 0 on top, bit4 leftmost; unknown codes return a solid row.
  function automatic logic [4:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [24:0] g;
    case (d)
      4'd0: g = 25'b01110_10001_10001_10001_01110;
      4'd1: g = 25'b01100_00100_00100_00100_01110;
      4'd2: g = 25'b11110_00001_01110_10000_11111;
      4'd3: g = 25'b11110_00001_00110_00001_11110;
      4'd4: g = 25'b10010_10010_11111_00010_00010;
      4'd5: g = 25'b11111_10000_11110_00001_11110;
      4'd6: g = 25'b01111_10000_11110_10001_01110;
      4'd7: g = 25'b11111_00010_00100_01000_01000;
      4'd8: g = 25'b01110_10001_01110_10001_01110;
      4'd9: g = 25'b01110_10001_01111_00001_01110;
      default: g = 25'h1FFFFFF;
    endcase
    if (r > 3'd4) return 5'b00000;
    else return g[24 - 5 * int'(r) -: 5];
  endfunction

  always_comb intf.bits = font_row(intf.digit, intf.yofs);

  // Reference pixel straight from screen coordinates.
  function automatic logic exp_pix(input int h, input int v, input logic disp,
                                   input logic [15:0] sc);
    int rel, col, slot, row;
    logic [3:0] d;
    logic [4:0] rowbits;
    if (!disp || h < 16 || h >= 80 || v < 8 || v >= 18) return 1'b0;
    rel  = h - 16;
    col  = (rel % 16) / 2;
    if (col >= 5) return 1'b0;
    slot = rel / 16;
    d    = sc[15 - 4 * slot -: 4];
    row  = (v - 8) / 2;
    rowbits = font_row(d, 3'(row));
    return rowbits[4 - col];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    intf.score_clr = 1'b1;
    tick();
    intf.score_clr = 1'b0;
  endtask

  task automatic do_add(input logic [3:0] v);
    int k;
    intf.add_req = 1'b1;
    intf.add_val = v;
    tick();
    intf.add_req = 1'b0;
    k = 0;
    while (k < 10 && intf.add_ack !== 1'b1) begin
      tick();
      k++;
    end
    checks++;
    if (intf.add_ack !== 1'b1) begin
      errors++;
      $display("FAIL add_timeout: add_ack=%b required 1 within 10 cycles", intf.add_ack);
    end
  endtask

  task automatic load_score(input int n);
    int rem;
    do_clear();
    rem = n;
    while (rem > 0) begin
      if (rem >= 9) begin
        do_add(4'd9);
        rem -= 9;
      end else begin
        do_add(4'(rem));
        rem = 0;
      end
    end
  endtask

  task automatic test_reset();
    intf.add_req = 1'b0; intf.add_val = 4'd0; intf.score_clr = 1'b0;
    intf.hpos = 9'd0; intf.vpos = 9'd0; intf.display_on = 1'b0;
    reset = 1'b0;
    #12;
    checks++;
    if ({intf.score, intf.busy, intf.add_ack, intf.ovf, intf.digit, intf.yofs, intf.gfx}
        !== {16'h0000, 1'b0, 1'b0, 1'b0, 4'hF, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: score=%h busy=%b ack=%b ovf=%b digit=%h yofs=%0d gfx=%b required 0000 0 0 0 f 0 0",
               intf.score, intf.busy, intf.add_ack, intf.ovf, intf.digit, intf.yofs, intf.gfx);
    end
    reset = 1'b1;
    tick();
    // Reset mid-ADD2 with the score at 0123.
    load_score(123);
    intf.add_req = 1'b1; intf.add_val = 4'd1;
    tick();
    intf.add_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #2;
    checks++;
    if ({intf.score, intf.busy, intf.gfx, intf.add_ack} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_add: score=%h busy=%b gfx=%b ack=%b required 0000 0 0 0",
               intf.score, intf.busy, intf.gfx, intf.add_ack);
    end
    #2;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (intf.add_ack !== 1'b0 || intf.busy !== 1'b0 || intf.score !== 16'h0000) begin
        errors++;
        $display("FAIL reset_no_ack: cycle %0d ack=%b busy=%b score=%h required 0 0 0000",
                 i, intf.add_ack, intf.busy, intf.score);
      end
    end
  endtask

  task automatic test_carry_ripple();
    int busy_cnt;
    logic [15:0] exp_sc [0:4];
    exp_sc[0] = 16'h0999; exp_sc[1] = 16'h0990; exp_sc[2] = 16'h0900;
    exp_sc[3] = 16'h0000; exp_sc[4] = 16'h1000;
    load_score(999);
    busy_cnt = 0;
    intf.add_req = 1'b1; intf.add_val = 4'd1;
    for (int e = 0; e < 5; e++) begin
      tick();
      intf.add_req = 1'b0;
      if (intf.busy === 1'b1) busy_cnt++;
      checks++;
      if (intf.score !== exp_sc[e]) begin
        errors++;
        $display("FAIL ripple_score: E%0d score=%h required %h", e, intf.score, exp_sc[e]);
      end
    end
    checks++;
    if ({intf.add_ack, intf.ovf, intf.busy} !== 3'b100) begin
      errors++;
      $display("FAIL ripple_ack: ack=%b ovf=%b busy=%b required 1 0 0",
               intf.add_ack, intf.ovf, intf.busy);
    end
    checks++;
    if (busy_cnt !== 4) begin
      errors++;
      $display("FAIL ripple_busy_len: busy cycles=%0d required 4", busy_cnt);
    end
    tick();
    checks++;
    if (intf.add_ack !== 1'b0) begin
      errors++;
      $display("FAIL ripple_ack_pulse: ack=%b required 0", intf.add_ack);
    end
  endtask

  task automatic test_wrap_clamp();
    load_score(9995);
    checks++;
    if (intf.score !== 16'h9995) begin
      errors++;
      $display("FAIL wrap_preload: score=%h required 9995", intf.score);
    end
    intf.add_req = 1'b1; intf.add_val = 4'd15;
    tick();
    intf.add_req = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if ({intf.score, intf.add_ack, intf.ovf} !== {16'h0004, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_clamp: score=%h ack=%b ovf=%b required 0004 1 1",
               intf.score, intf.add_ack, intf.ovf);
    end
    tick();
    checks++;
    if ({intf.add_ack, intf.ovf} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_ovf_pulse: ack=%b ovf=%b required 0 0", intf.add_ack, intf.ovf);
    end
  endtask

  task automatic test_clear_priority();
    for (int pass = 0; pass < 2; pass++) begin
      load_score(42);
      intf.add_req = 1'b1; intf.add_val = 4'd5;
      if (pass == 0) begin
        intf.score_clr = 1'b1;
        tick();
      end else begin
        tick();
        intf.add_req = 1'b0;
        tick();
        intf.score_clr = 1'b1;
        tick();
      end
      intf.score_clr = 1'b0;
      intf.add_req = 1'b0;
      checks++;
      if ({intf.score, intf.busy} !== {16'h0000, 1'b0}) begin
        errors++;
        $display("FAIL clear_prio: pass %0d score=%h busy=%b required 0000 0",
                 pass, intf.score, intf.busy);
      end
      for (int i = 0; i < 6; i++) begin
        tick();
        checks++;
        if ({intf.add_ack, intf.busy, intf.score} !== {1'b0, 1'b0, 16'h0000}) begin
          errors++;
          $display("FAIL clear_no_ack: pass %0d cycle %0d ack=%b busy=%b score=%h required 0 0 0000",
                   pass, i, intf.add_ack, intf.busy, intf.score);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    int first_ack;
    do_clear();
    acks = 0;
    first_ack = -1;
    intf.add_req = 1'b1; intf.add_val = 4'd1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (intf.add_ack === 1'b1) begin
        acks++;
        if (first_ack < 0) first_ack = i;
      end
    end
    intf.add_req = 1'b0;
    checks++;
    if (acks !== 3 || first_ack !== 4 || intf.score !== 16'h0003) begin
      errors++;
      $display("FAIL back_to_back: acks=%0d first=%0d score=%h required 3 4 0003",
               acks, first_ack, intf.score);
    end
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (intf.busy !== 1'b0 || intf.score !== 16'h0003) begin
      errors++;
      $display("FAIL back_to_back_stop: busy=%b score=%h required 0 0003", intf.busy, intf.score);
    end
  endtask

  task automatic test_render();
    load_score(1000);
    intf.display_on = 1'b1;
    intf.hpos = 9'd16; intf.vpos = 9'd8;
    tick();
    checks++;
    if ({intf.digit, intf.yofs} !== {4'd1, 3'd0}) begin
      errors++;
      $display("FAIL render_addr: digit=%h yofs=%0d required 1 0", intf.digit, intf.yofs);
    end
    intf.hpos = 9'd18;
    tick();
    checks++;
    if (intf.gfx !== 1'b0) begin
      errors++;
      $display("FAIL render_h16: gfx=%b required 0", intf.gfx);
    end
    intf.hpos = 9'd26;
    tick();
    checks++;
    if (intf.gfx !== 1'b1 || intf.digit !== 4'hF) begin
      errors++;
      $display("FAIL render_h18: gfx=%b digit=%h required 1 f", intf.gfx, intf.digit);
    end
    tick();
    checks++;
    if (intf.gfx !== 1'b0) begin
      errors++;
      $display("FAIL render_h26: gfx=%b required 0", intf.gfx);
    end
  endtask

  task automatic test_field_bounds();
    logic prev_exp;
    int prev_h, prev_v;
    logic first;
    for (int pass = 0; pass < 2; pass++) begin
      first = 1'b1;
      prev_exp = 1'b0; prev_h = 0; prev_v = 0;
      intf.display_on = (pass == 0);
      for (int v = 0; v <= 20; v++) begin
        for (int h = 0; h <= 100; h++) begin
          intf.hpos = 9'(h);
          intf.vpos = 9'(v);
          tick();
          if (!first) begin
            checks++;
            if (intf.gfx !== prev_exp) begin
              errors++;
              $display("FAIL field_pixel: disp=%0d h=%0d v=%0d gfx=%b required %b",
                       pass == 0, prev_h, prev_v, intf.gfx, prev_exp);
            end
          end
          first = 1'b0;
          prev_exp = exp_pix(h, v, intf.display_on, 16'h1000);
          prev_h = h; prev_v = v;
        end
      end
      tick();
      checks++;
      if (intf.gfx !== prev_exp) begin
        errors++;
        $display("FAIL field_last: gfx=%b required %b", intf.gfx, prev_exp);
      end
    end
    intf.display_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_wrap_clamp();
    test_clear_priority();
    test_back_to_back();
    test_render();
    test_field_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
